// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive monitor: frame parity mode, receiver states, FIFO entry width.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_e;

    // Entry layout is {frame_err, parity_err, data}.
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: head is readable combinationally, a push becomes visible the next cycle.
// Push while full is accepted only if a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                           clk_25mhz,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_dat,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LW'(DEPTH));
    assign level     = r_level;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    // Gate the head so the output reads zero rather than stale storage when empty.
    assign head_dat  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_25mhz) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver: mid-bit sampling of the synchronised line, characters + error flags queued in a FIFO.
// Character visible the cycle after its last stop sample; full FIFO drops the character and flags overrun.
module uart_rx_monitor
    import uart_rx_pkg::*;
#(
    parameter int      CLK_DIV    = 217,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                              clk_25mhz,
    input  logic                              rst_n,
    input  logic                              rxd,
    input  logic                              enable,
    output logic [DATA_BITS-1:0]              out_data,
    output logic                              out_frame_err,
    output logic                              out_parity_err,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overrun,
    input  logic                              clear_overrun,
    output logic                              break_det
);

    localparam int EW = entry_width(DATA_BITS);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLK_DIV);

    logic [1:0]           r_sync;
    logic                 r_rxs_prev;
    rx_state_e            r_state;
    rx_state_e            w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_stop_hi;
    logic                 r_overrun;

    logic                 w_rxs;
    logic                 w_start;
    logic                 w_tick;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_par_err;
    logic                 w_frame_err;
    logic                 w_all_zero;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [EW-1:0]        w_head;

    assign w_rxs       = r_sync[1];
    assign w_start     = enable & r_rxs_prev & ~w_rxs;
    assign w_tick      = (r_cnt == CW'(1));
    assign w_last_data = (r_bit_idx == 4'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_idx == 4'(STOP_BITS - 1));
    assign w_par_err   = (PARITY == PAR_ODD) ? ~(^r_shift ^ w_rxs) : (^r_shift ^ w_rxs);
    assign w_frame_err = r_frame_err | ~w_rxs;
    // A frame of all zeros, stop bits included, is a line break rather than a character.
    assign w_all_zero  = (r_shift == '0) & ~r_par_bit & ~r_stop_hi & ~w_rxs;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxs_prev <= w_rxs;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_START;
            S_START:  if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && w_last_data) begin
                          w_state_nxt = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                      end
            S_PARITY: if (w_tick) w_state_nxt = S_STOP;
            S_STOP:   if (w_tick && w_last_stop) begin
                          if (w_all_zero) begin
                              w_state_nxt = S_BREAK;
                          end else begin
                              w_push      = 1'b1;
                              w_state_nxt = S_IDLE;
                          end
                      end
            S_BREAK:  if (w_rxs) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_push      = 1'b0;
        end
    end

    // Bit timer free-runs outside IDLE; IDLE keeps it preloaded for the half-bit start sample.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_stop_hi   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt       <= HALF_BIT;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_stop_hi   <= 1'b0;
        end else begin
            r_cnt <= w_tick ? FULL_BIT : r_cnt - CW'(1);
            if (w_tick) begin
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= w_last_data ? 4'd0 : r_bit_idx + 4'd1;
                    end
                    S_PARITY: begin
                        r_par_bit <= w_rxs;
                        r_par_err <= w_par_err;
                    end
                    S_STOP: begin
                        r_frame_err <= w_frame_err;
                        r_stop_hi   <= r_stop_hi | w_rxs;
                        r_bit_idx   <= r_bit_idx + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_pop = ~w_empty & out_ready;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_dat  ({w_frame_err, r_par_err, r_shift}),
        .pop       (w_pop),
        .head_dat  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    assign out_valid      = ~w_empty;
    assign out_data       = w_head[DATA_BITS-1:0];
    assign out_parity_err = w_head[DATA_BITS];
    assign out_frame_err  = w_head[DATA_BITS+1];
    assign overrun        = r_overrun;
    assign break_det      = (r_state == S_BREAK);

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Parametrised UART receiver that decodes the FPGA `ftdi_rxd` line inside the simulation top, replacing passive waveform dumping of the serial output. It samples the line with a configurable clock divider and supports configurable frame format. Decoded characters, with per-character error flags, are buffered in a FIFO and presented on a valid/ready stream for the cocotb bench. Line-level events (break, overrun) are reported on separate status outputs.

## Interface
- `CLK_DIV`, 217: clock cycles per bit (217 ≈ 115200 baud at 25 MHz); ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, PAR_NONE: PAR_NONE / PAR_ODD / PAR_EVEN.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries; power of 2, ≥ 2.

- `clk_25mhz` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial line, asynchronous, idle high.
- `enable` in 1: receiver enable.
- `out_data` out DATA_BITS: head-of-FIFO character.
- `out_frame_err` out 1: head character had a low stop bit.
- `out_parity_err` out 1: head character failed the parity check.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: pop when `out_valid & out_ready`.
- `fifo_level` out $clog2(FIFO_DEPTH+1): occupancy.
- `overrun` out 1: sticky; character dropped because the FIFO was full.
- `clear_overrun` in 1: clears `overrun`.
- `break_det` out 1: break condition in progress.

## Operation
- `rxd` passes through a 2-FF synchroniser; both FFs reset to 1. All logic uses the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on `rxs` 1→0 with `enable` high, go to START and load the bit counter with CLK_DIV/2 (floor).
  - START: at the half-bit sample, `rxs`=1 means a false start; return to IDLE with no push. `rxs`=0 goes to DATA.
  - DATA: sample every CLK_DIV cycles, LSB first, into the shift register. After DATA_BITS samples, go to PARITY if PARITY≠NONE, otherwise STOP.
  - PARITY: one sample. Error if the XOR of data and parity bit is 0 for odd parity, or 1 for even parity.
  - STOP: STOP_BITS samples. Any low stop sample sets the frame error.
    - After the last stop sample, if the data bits, the parity bit (if present) and the stop bits were all 0: go to BREAK, set `break_det`, push nothing.
    - Otherwise push {frame_err, parity_err, data} and go to IDLE in the same cycle.
  - BREAK: wait for `rxs`=1, then clear `break_det` and go to IDLE.
- `enable` low: FSM goes to IDLE on the next edge and the partial frame is discarded. FIFO contents, `overrun` and `break_det` are unaffected, except that BREAK exits to IDLE and `break_det` clears.
- FIFO rules:
  - A push into a full FIFO is dropped and sets `overrun`. A push and a pop in the same cycle when full is accepted, with no overrun.
  - A pop when empty is ignored.
  - If `clear_overrun` and a new overrun occur in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately and the FIFO is emptied.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty.
  - `out_valid`, `fifo_level`, `overrun`, `break_det`, `out_frame_err`, `out_parity_err` are 0; `out_data` is 0.
- `rxs` lags `rxd` by 2 cycles. Let t0 be the first cycle with `rxs`=0 in IDLE.
  - Start sample: t0 + floor(CLK_DIV/2).
  - Bit k sample (k=1 is the first data bit): t0 + floor(CLK_DIV/2) + k·CLK_DIV.
  - `out_valid` rises, and `fifo_level` increments, the cycle after the last stop sample.
- FIFO is show-ahead. `out_data`/flags are valid combinationally from the registered head whenever `out_valid` is high, and advance the cycle after a pop.
- `overrun` is set the cycle after the dropped push.
- `break_det` rises the cycle after the last stop sample and falls the cycle after `rxs` returns to 1.

## Structure
- `uart_rx_pkg`: `parity_e` (PAR_NONE, PAR_ODD, PAR_EVEN), `rx_state_e` enum, and the entry-width function DATA_BITS+2.
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, and ports push/pop/full/empty/level. The top-level module holds the synchroniser, FSM, bit counter and shift register.

## Test plan
Parameters CLK_DIV=8, 8N1 unless stated.
- Send 0xA5 → one entry, `out_data`=0xA5, both errors 0, `out_valid` rises at t0+4+9·8+1.
- PARITY=EVEN, send 0x07 with parity bit 0 → `out_parity_err`=1, `out_data`=0x07. With parity bit 1 → no error.
- 2-cycle low glitch on `rxd` → no push, FSM back in IDLE, `fifo_level`=0.
- FIFO_DEPTH=4, `out_ready`=0, send 0x01..0x05 → `fifo_level`=4, `overrun`=1, pops return 0x01..0x04. A `clear_overrun` pulse → `overrun`=0.
- Hold `rxd` low for 20 bit times → `break_det`=1, no push. Release, then send 0x3C → `break_det`=0, entry 0x3C with no errors.
- Assert `rst_n` low mid-data-bit with 2 entries queued → all outputs at reset values. After release, send 0x5A → received correctly.
